// File: rtl/mfcc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mfcc_pkg
//  Purpose  : Shared types and defaults for the MFCC per-frame sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mfcc_pkg;

   // Stage index along the per-frame datapath
   typedef enum logic [1:0] {
      STG_HAMMING = 2'd0,
      STG_FFT     = 2'd1,
      STG_MEL     = 2'd2,
      STG_DCT     = 2'd3
   } stage_e;

   // Sequencer state
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   localparam int DEF_MAX_PENDING    = 2;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage
`default_nettype wire

// File: rtl/mfcc_stage_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : mfcc_stage_watchdog
//  Purpose  : Per-stage cycle counter; flags the last allowed wait cycle.
//             A LIMIT of 0 disables the watchdog entirely.
//  Revision : 1.0 - initial release
// ============================================================================
module mfcc_stage_watchdog
   import mfcc_pkg::*;
#(
   parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic count_en_i,
   output logic expired_o
);

   localparam int CW     = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam int LIM_M1 = (LIMIT == 0) ? 0 : LIMIT - 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear wins over counting
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry fires in the wait cycle that holds the final allowed count
   generate
      if (LIMIT == 0) begin : g_disabled
         assign expired_o = 1'b0;
      end else begin : g_enabled
         assign expired_o = count_en_i && (count_q == CW'(LIM_M1));
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/mfcc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mfcc_frame_sequencer
//  Purpose  : Queues frame-ready pulses and walks each frame through the
//             Hamming -> FFT -> MEL -> DCT stages with start/done handshakes,
//             keeping frame/drop counters and sticky overrun/timeout flags.
//  Revision : 1.0 - initial release
// ============================================================================
module mfcc_frame_sequencer
   import mfcc_pkg::*;
#(
   parameter int NUM_STAGES     = 4,
   parameter int MAX_PENDING    = DEF_MAX_PENDING,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int COUNT_WIDTH    = 16,
   localparam int SW = (NUM_STAGES < 2) ? 1 : $clog2(NUM_STAGES),
   localparam int PW = $clog2(MAX_PENDING + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable_i,
   input  logic                   frame_ready_i,
   output logic [NUM_STAGES-1:0]  stage_start_o,
   input  logic [NUM_STAGES-1:0]  stage_done_i,
   output logic                   busy_o,
   output logic [SW-1:0]          active_stage_o,
   output logic                   frame_done_o,
   output logic [COUNT_WIDTH-1:0] frame_count_o,
   output logic [COUNT_WIDTH-1:0] dropped_count_o,
   output logic [PW-1:0]          pending_o,
   output logic                   overrun_o,
   output logic                   timeout_o,
   output logic [SW-1:0]          timeout_stage_o,
   input  logic                   clear_errors_i
);

   seq_state_e             state_q,       state_d;
   logic [SW-1:0]          stage_q,       stage_d;
   logic [PW-1:0]          pending_q,     pending_d;
   logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
   logic [COUNT_WIDTH-1:0] dropped_q,     dropped_d;
   logic                   overrun_q,     overrun_d;
   logic                   timeout_q,     timeout_d;
   logic [SW-1:0]          tstage_q,      tstage_d;

   logic w_dispatch;
   logic w_drop;
   logic w_timeout_evt;
   logic w_wd_expired;

   // Watchdog counts only while waiting on a stage; any other state resets it
   mfcc_stage_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (state_q != WAIT),
      .count_en_i (state_q == WAIT),
      .expired_o  (w_wd_expired)
   );

   // Next-state, queue and error bookkeeping
   always_comb begin
      state_d       = state_q;
      stage_d       = stage_q;
      pending_d     = pending_q;
      frame_count_d = frame_count_q;
      dropped_d     = dropped_q;
      tstage_d      = tstage_q;
      w_timeout_evt = 1'b0;

      w_dispatch = (state_q == IDLE) && enable_i &&
                   ((pending_q != '0) || frame_ready_i);

      case (state_q)
         IDLE: begin
            if (w_dispatch) begin
               state_d = START;
               stage_d = SW'(STG_HAMMING);
            end
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            // A done in the final watchdog cycle still completes the stage
            if (stage_done_i[stage_q]) begin
               if (stage_q == SW'(NUM_STAGES - 1)) begin
                  state_d = DONE;
               end else begin
                  stage_d = stage_q + 1'b1;
                  state_d = START;
               end
            end else if (w_wd_expired) begin
               w_timeout_evt = 1'b1;
               tstage_d      = stage_q;
               stage_d       = '0;
               state_d       = IDLE;
            end
         end
         DONE: begin
            frame_count_d = frame_count_q + 1'b1;
            stage_d       = '0;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A dispatch frees a slot in the same cycle, so a full queue never drops then
      w_drop = frame_ready_i && !w_dispatch && (pending_q == PW'(MAX_PENDING));
      if (frame_ready_i && !w_dispatch && !w_drop) begin
         pending_d = pending_q + 1'b1;
      end else if (!frame_ready_i && w_dispatch) begin
         pending_d = pending_q - 1'b1;
      end

      // A new error in the clearing cycle survives the clear
      overrun_d = (overrun_q && !clear_errors_i) || w_drop;
      timeout_d = (timeout_q && !clear_errors_i) || w_timeout_evt;
      if (w_drop) begin
         if (clear_errors_i) begin
            dropped_d = COUNT_WIDTH'(1);
         end else if (dropped_q != '1) begin
            dropped_d = dropped_q + 1'b1;
         end
      end else if (clear_errors_i) begin
         dropped_d = '0;
      end
   end

   // Sequencer and status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         stage_q       <= '0;
         pending_q     <= '0;
         frame_count_q <= '0;
         dropped_q     <= '0;
         overrun_q     <= 1'b0;
         timeout_q     <= 1'b0;
         tstage_q      <= '0;
      end else begin
         state_q       <= state_d;
         stage_q       <= stage_d;
         pending_q     <= pending_d;
         frame_count_q <= frame_count_d;
         dropped_q     <= dropped_d;
         overrun_q     <= overrun_d;
         timeout_q     <= timeout_d;
         tstage_q      <= tstage_d;
      end
   end

   // One-hot start decode from registered state
   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_start
         assign stage_start_o[gi] = (state_q == START) && (stage_q == SW'(gi));
      end
   endgenerate

   assign busy_o          = (state_q != IDLE);
   assign frame_done_o    = (state_q == DONE);
   assign active_stage_o  = stage_q;
   assign frame_count_o   = frame_count_q;
   assign dropped_count_o = dropped_q;
   assign pending_o       = pending_q;
   assign overrun_o       = overrun_q;
   assign timeout_o       = timeout_q;
   assign timeout_stage_o = tstage_q;

endmodule
`default_nettype wire

// File: tb/tb_mfcc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mfcc_frame_sequencer
//  Purpose  : Self-checking bench for mfcc_frame_sequencer with a reactive
//             stage responder and a frame-level timing model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mfcc_frame_sequencer;

   localparam int NS = 4;
   localparam int MP = 2;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable_i = 1'b0;
   logic        frame_ready_i = 1'b0;
   logic        clear_errors_i = 1'b0;
   logic [3:0]  resp_done = '0;
   logic [3:0]  extra_done = '0;
   logic [3:0]  stage_done_i;
   logic [3:0]  stage_start_o;
   logic        busy_o;
   logic [1:0]  active_stage_o;
   logic        frame_done_o;
   logic [15:0] frame_count_o;
   logic [15:0] dropped_count_o;
   logic [1:0]  pending_o;
   logic        overrun_o;
   logic        timeout_o;
   logic [1:0]  timeout_stage_o;

   assign stage_done_i = resp_done | extra_done;

   mfcc_frame_sequencer #(
      .NUM_STAGES(NS), .MAX_PENDING(MP), .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .frame_ready_i(frame_ready_i),
      .stage_start_o(stage_start_o), .stage_done_i(stage_done_i), .busy_o(busy_o),
      .active_stage_o(active_stage_o), .frame_done_o(frame_done_o),
      .frame_count_o(frame_count_o), .dropped_count_o(dropped_count_o),
      .pending_o(pending_o), .overrun_o(overrun_o), .timeout_o(timeout_o),
      .timeout_stage_o(timeout_stage_o), .clear_errors_i(clear_errors_i)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Per-stage response delay (cycles from start to done) and muted stages
   int d [NS] = '{3, 3, 3, 3};
   bit mute [NS] = '{0, 0, 0, 0};
   bit chk_en = 0;

   // ---------------- frame-level reference model ----------------
   // A dispatched frame occupies the sequencer for a fixed number of cycles:
   // each stage costs its start cycle plus its wait cycles, then one DONE
   // cycle; a silent stage ends the frame after TO wait cycles instead.
   int          m_left = 0, m_T = 0, m_pend = 0, m_dropped = 0, m_tstage = 0, m_mstage = 0;
   bit          m_complete = 0, m_overrun = 0, m_timeout = 0;
   logic [15:0] m_count = '0;

   always @(posedge clk) begin : model_p
      bit disp, drop, to_evt;
      int t;
      if (!rst_n) begin
         m_left = 0; m_pend = 0; m_dropped = 0; m_tstage = 0;
         m_overrun = 0; m_timeout = 0; m_count = '0;
      end else begin
         disp = 0; drop = 0; to_evt = 0;
         if (m_left == 0) begin
            disp = enable_i && (m_pend > 0 || frame_ready_i);
         end else begin
            if (m_left == 1) begin
               if (m_complete) m_count = m_count + 16'd1;
               else to_evt = 1;
            end
            m_left--;
         end
         if (frame_ready_i && !disp && m_pend == MP) drop = 1;
         else if (frame_ready_i && !disp) m_pend++;
         else if (!frame_ready_i && disp) m_pend--;
         m_overrun = (m_overrun && !clear_errors_i) || drop;
         if (drop) m_dropped = clear_errors_i ? 1 : ((m_dropped == 65535) ? 65535 : m_dropped + 1);
         else if (clear_errors_i) m_dropped = 0;
         if (to_evt) m_tstage = m_mstage;
         m_timeout = (m_timeout && !clear_errors_i) || to_evt;
         if (disp) begin
            t = 0; m_complete = 1;
            for (int i = 0; i < NS; i++) begin
               if (mute[i]) begin
                  t += 1 + TO; m_complete = 0; m_mstage = i;
                  break;
               end
               t += 1 + d[i];
            end
            if (m_complete) t += 1;
            m_T = t; m_left = t;
         end
      end
   end

   // Per-cycle scoreboard against the model
   always @(negedge clk) begin : monitor_p
      logic [3:0]  exp_start;
      logic [43:0] exp_v, act_v;
      int e, off;
      if (chk_en) begin
         exp_start = '0;
         if (m_left > 0) begin
            e = m_T - m_left; off = 0;
            for (int i = 0; i < NS; i++) begin
               if (e == off) exp_start[i] = 1'b1;
               if (mute[i]) break;
               off += 1 + d[i];
            end
         end
         exp_v = {m_left > 0, (m_left == 1) && m_complete, exp_start, 2'(m_pend),
                  m_count, 16'(m_dropped), m_overrun, m_timeout, 2'(m_tstage)};
         act_v = {busy_o, frame_done_o, stage_start_o, pending_o, frame_count_o,
                  dropped_count_o, overrun_o, timeout_o, timeout_stage_o};
         tests_run++;
         if (act_v !== exp_v) begin
            tests_failed++;
            $display("FAIL cycle_model t=%0t {busy,fdone,start,pend,cnt,drop,ovr,to,tstg} got %h expected %h",
                     $time, act_v, exp_v);
         end
      end
   end

   // Stage responder: answers each start pulse with a done d[stage] cycles later
   int resp_cnt = 0, resp_stage = 0;
   int start_log [$];

   always @(negedge clk) begin : responder_p
      resp_done = '0;
      if (!rst_n) begin
         resp_cnt = 0;
      end else begin
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) resp_done[resp_stage] = 1'b1;
         end
         for (int i = NS - 1; i >= 0; i--) begin
            if (stage_start_o[i]) begin
               resp_stage = i;
               resp_cnt   = mute[i] ? 0 : d[i];
            end
         end
         for (int i = 0; i < NS; i++) if (stage_start_o[i]) start_log.push_back(i);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_frame();
      frame_ready_i = 1'b1;
      @(negedge clk);
      frame_ready_i = 1'b0;
   endtask

   task automatic drain(input int max_cycles, input string name);
      int n = 0;
      while ((m_left != 0 || m_pend != 0 || busy_o) && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (n >= max_cycles) begin
         tests_failed++;
         $display("FAIL drain_%s busy=%0b pending=%0d still active after %0d cycles, required idle",
                  name, busy_o, pending_o, n);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      tests_run++;
      if ({stage_start_o, busy_o, frame_done_o, frame_count_o, dropped_count_o, pending_o,
           overrun_o, timeout_o, timeout_stage_o, active_stage_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs start=%b busy=%b cnt=%0d drop=%0d pend=%0d, required all zero",
                  stage_start_o, busy_o, frame_count_o, dropped_count_o, pending_o);
      end
      rst_n = 1'b1;
      chk_en = 1;
      tick(1);
   endtask

   task automatic test_single_frame();
      bit ok;
      d = '{3, 3, 3, 3};
      start_log.delete();
      enable_i = 1'b1;
      pulse_frame();
      tests_run++;
      if (stage_start_o !== 4'b0001) begin
         tests_failed++;
         $display("FAIL single_start_latency start=%b, required 0001", stage_start_o);
      end
      drain(100, "single");
      ok = (start_log.size() == 4);
      for (int i = 0; i < start_log.size() && i < 4; i++) ok &= (start_log[i] == i);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL single_start_order got %p, required 0 1 2 3", start_log);
      end
      tests_run++;
      if (frame_count_o !== 16'd1 || busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_count count=%0d busy=%b, required 1 and 0", frame_count_o, busy_o);
      end
   endtask

   task automatic test_queueing();
      int peak = 0;
      start_log.delete();
      pulse_frame();
      for (int k = 0; k < 3; k++) begin
         tick(1);
         pulse_frame();
         if (int'(pending_o) > peak) peak = int'(pending_o);
      end
      tests_run++;
      if (peak != 2 || overrun_o !== 1'b1 || dropped_count_o !== 16'd1) begin
         tests_failed++;
         $display("FAIL queue_overrun peak=%0d overrun=%b dropped=%0d, required 2 1 1",
                  peak, overrun_o, dropped_count_o);
      end
      drain(200, "queue");
      tests_run++;
      if (frame_count_o !== 16'd4 || start_log.size() != 12) begin
         tests_failed++;
         $display("FAIL queue_frames count=%0d starts=%0d, required 4 and 12",
                  frame_count_o, start_log.size());
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      d = '{2, 2, 2, 2};
      mute[1] = 1;
      start_log.delete();
      pulse_frame();
      while (busy_o && n < 100) begin
         n++;
         @(negedge clk);
      end
      tests_run++;
      if (n != 1 + 2 + 1 + TO) begin
         tests_failed++;
         $display("FAIL timeout_duration busy cycles=%0d, required %0d", n, 1 + 2 + 1 + TO);
      end
      tests_run++;
      if (timeout_o !== 1'b1 || timeout_stage_o !== 2'd1 || frame_count_o !== 16'd4 || start_log.size() != 2) begin
         tests_failed++;
         $display("FAIL timeout_flags to=%b stage=%0d count=%0d starts=%0d, required 1 1 4 2",
                  timeout_o, timeout_stage_o, frame_count_o, start_log.size());
      end
      mute[1] = 0;
      clear_errors_i = 1'b1;
      tick(1);
      clear_errors_i = 1'b0;
      tests_run++;
      if (timeout_o !== 1'b0 || overrun_o !== 1'b0 || dropped_count_o !== 16'd0) begin
         tests_failed++;
         $display("FAIL clear_errors to=%b ovr=%b dropped=%0d, required 0 0 0",
                  timeout_o, overrun_o, dropped_count_o);
      end
   endtask

   task automatic test_enable_gating();
      for (int i = 0; i < NS; i++) d[i] = $urandom_range(1, 4);
      enable_i = 1'b0;
      start_log.delete();
      pulse_frame();
      tick(1);
      pulse_frame();
      tick(3);
      tests_run++;
      if (start_log.size() != 0 || pending_o !== 2'd2) begin
         tests_failed++;
         $display("FAIL gate_hold starts=%0d pending=%0d, required 0 and 2", start_log.size(), pending_o);
      end
      enable_i = 1'b1;
      tick(1);
      tests_run++;
      if (stage_start_o !== 4'b0001) begin
         tests_failed++;
         $display("FAIL gate_release start=%b, required 0001", stage_start_o);
      end
      drain(300, "gate");
      tests_run++;
      if (frame_count_o !== 16'd6) begin
         tests_failed++;
         $display("FAIL gate_count count=%0d, required 6", frame_count_o);
      end
   endtask

   task automatic test_robustness();
      bit ok;
      d = '{4, 4, 4, 4};
      pulse_frame();
      tick(1);
      extra_done = 4'b0100;
      tick(1);
      extra_done = 4'b0000;
      tests_run++;
      if (stage_start_o !== 4'b0000 || active_stage_o !== 2'd0 || busy_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL spurious_done start=%b stage=%0d busy=%b, required 0000 0 1",
                  stage_start_o, active_stage_o, busy_o);
      end
      tick(4);
      rst_n = 1'b0;
      tick(2);
      tests_run++;
      if ({stage_start_o, busy_o, frame_done_o, frame_count_o, dropped_count_o, pending_o,
           overrun_o, timeout_o, timeout_stage_o, active_stage_o} !== '0) begin
         tests_failed++;
         $display("FAIL midframe_reset start=%b busy=%b stage=%0d cnt=%0d, required all zero",
                  stage_start_o, busy_o, active_stage_o, frame_count_o);
      end
      rst_n = 1'b1;
      tick(1);
      start_log.delete();
      pulse_frame();
      drain(100, "after_reset");
      ok = (start_log.size() == 4);
      for (int i = 0; i < start_log.size() && i < 4; i++) ok &= (start_log[i] == i);
      tests_run++;
      if (!ok || frame_count_o !== 16'd1) begin
         tests_failed++;
         $display("FAIL after_reset_frame starts=%p count=%0d, required 0 1 2 3 and 1",
                  start_log, frame_count_o);
      end
   endtask

   task automatic test_clear_collision();
      enable_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pulse_frame();
         tick(1);
      end
      tests_run++;
      if (overrun_o !== 1'b1 || dropped_count_o !== 16'd2) begin
         tests_failed++;
         $display("FAIL pre_collision ovr=%b dropped=%0d, required 1 and 2", overrun_o, dropped_count_o);
      end
      frame_ready_i  = 1'b1;
      clear_errors_i = 1'b1;
      tick(1);
      frame_ready_i  = 1'b0;
      clear_errors_i = 1'b0;
      tests_run++;
      if (overrun_o !== 1'b1 || dropped_count_o !== 16'd1) begin
         tests_failed++;
         $display("FAIL clear_collision ovr=%b dropped=%0d, required 1 and 1", overrun_o, dropped_count_o);
      end
      enable_i = 1'b1;
      drain(200, "collision");
      tests_run++;
      if (frame_count_o !== 16'd3) begin
         tests_failed++;
         $display("FAIL collision_count count=%0d, required 3", frame_count_o);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < NS; i++) d[i] = $urandom_range(1, 5);
         for (int c = 0; c < 300; c++) begin
            frame_ready_i  = ($urandom_range(0, 5) == 0);
            enable_i       = ($urandom_range(0, 9) != 0);
            clear_errors_i = ($urandom_range(0, 30) == 0);
            tick(1);
         end
         frame_ready_i  = 1'b0;
         clear_errors_i = 1'b0;
         enable_i       = 1'b1;
         drain(500, "random");
         tests_run++;
         if (frame_count_o !== m_count) begin
            tests_failed++;
            $display("FAIL random_count count=%0d, required %0d", frame_count_o, m_count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_queueing();
      test_timeout();
      test_enable_gating();
      test_robustness();
      test_clear_collision();
      test_random();
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish, required completion");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
